load_unload_mem: RTL and testbench
==================================

# load_unload_mem

Responder side of the load/unload-memory handshake. The system controller issues `start`, `base_address`, `upper_limit` and `load_unload`, then waits for `ready`. This block moves one word per four-phase handshake between the C-program-facing GPIO registers and a single-port PNL BRAM, covering every address from base to upper limit inclusive. It sits between the PS/GPIO interface, the controller and the BRAM port mux.

## Interface
Parameters:
- `PNL_BRAM_ADDR_SIZE_NB`, 14, BRAM address width.
- `PNL_BRAM_DBITS_WIDTH_NB`, 16, BRAM / GPIO data word width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  controller request; sampled only in IDLE.
- `ready`  out  1  high when idle; low from the cycle after an accepted `start` until the transfer completes.
- `load_unload`  in  1  0 = load (C → BRAM), 1 = unload (BRAM → C); latched on `start`.
- `base_address`  in  ADDR  first address; latched on `start`.
- `upper_limit`  in  ADDR  last address, inclusive; latched on `start`.
- `CP_req`  in  1  C-side request, synchronous to `clk`.
- `CP_din`  in  DBITS  load data from C; valid while `CP_req` is high.
- `PL_ack`  out  1  handshake acknowledge to C.
- `PL_dout`  out  DBITS  unload data to C; valid while `PL_ack` is high.
- `BRAM_addr`  out  ADDR  BRAM address (registered).
- `BRAM_din`  out  DBITS  BRAM write data.
- `BRAM_we`  out  1  BRAM write enable.
- `BRAM_dout`  in  DBITS  BRAM read data; 1-cycle read latency.

## Operation
States: IDLE, WAIT_REQ, WRITE, READ, ACK.
- IDLE: `ready`=1.
  - When `start`=1: latch mode, `upper_limit` and data path; `BRAM_addr` ← `base_address`; go to WAIT_REQ.
- WAIT_REQ: wait for `CP_req`=1.
  - Load: capture `CP_din` into `BRAM_din`; go to WRITE.
  - Unload: go to READ.
- WRITE: `BRAM_we`=1 for exactly this one cycle at `BRAM_addr`; go to ACK.
- READ: capture `BRAM_dout` into `PL_dout` at the end of the cycle; go to ACK.
- ACK: `PL_ack`=1; wait for `CP_req`=0.
  - If `BRAM_addr` == latched upper limit: go to IDLE.
  - Otherwise: `BRAM_addr` ← `BRAM_addr`+1, modulo 2^ADDR; go to WAIT_REQ.

Rules:
- Word count is (upper − base) mod 2^ADDR + 1. If upper < base, the address wraps through the maximum address to 0. base == upper transfers exactly one word.
- `start` outside IDLE is ignored. Latched parameters do not change mid-transfer.
- `CP_req` held high after `PL_ack` rises causes no second transfer; the block waits in ACK.
- `BRAM_we` is never high outside WRITE.
- `PL_dout` holds its last value until the next READ.

Reset, asynchronous and active-low, from any state:
- State → IDLE.
- `ready`=1, `PL_ack`=0, `BRAM_we`=0.
- `BRAM_addr`=0, `BRAM_din`=0, `PL_dout`=0.
- An interrupted transfer is abandoned. No partial-write clean-up is required.

## Timing
- `start` accepted at edge T: `ready`=0 and `BRAM_addr`=base from T+1.
- `CP_req` seen high at edge R in WAIT_REQ:
  - Load: WRITE (`BRAM_we`=1) during R+1, `PL_ack`=1 from R+2.
  - Unload: READ during R+1, `PL_ack`=1 and `PL_dout` valid from R+2.
- `CP_req` seen low at edge F in ACK: `PL_ack`=0 from F+1.
  - Not last word: `BRAM_addr` increments at F+1 and the block is in WAIT_REQ at F+1.
  - Last word: `ready`=1 at F+1.
- Minimum 4 cycles per word with an immediate C-side response.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Test plan
- Load 4 words, base 0x010, upper 0x013, `CP_din` 0xA000..0xA003 → exactly 4 single-cycle `BRAM_we` pulses at addresses 0x010..0x013 with matching data; `ready` returns to 1 one cycle after the 4th `CP_req` falls.
- Unload 3 words, BRAM preloaded 0x5A5A, 0x1234, 0xFFFF at 0x100..0x102 → `PL_dout` presents those values in order, each valid while `PL_ack`=1; `BRAM_we` stays 0.
- Wrap and single-word cases:
  - base 0x3FFE, upper 0x0001, load → writes at 0x3FFE, 0x3FFF, 0x0000, 0x0001.
  - base == upper == 0x0050 → exactly one word.
- `CP_req` held high for 10 cycles after `PL_ack` rises, plus a `start` pulse mid-transfer → one transfer only; the `start` is ignored and the latched limits are unchanged.
- `reset` asserted during the ACK of word 2 of 5 → immediately `ready`=1, `PL_ack`=0, `BRAM_we`=0; a fresh `start` after release runs a clean full transfer.

Source files
------------

// File: rtl/load_unload_mem.sv
// Responder for the load/unload-memory handshake: moves one word per four-phase
// C-side handshake between the GPIO registers and the PNL BRAM, base..upper inclusive.
module load_unload_mem #(
  parameter int unsigned PNL_BRAM_ADDR_SIZE_NB   = 14,
  parameter int unsigned PNL_BRAM_DBITS_WIDTH_NB = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  output logic                               ready,
  input  logic                               load_unload,
  input  logic [PNL_BRAM_ADDR_SIZE_NB-1:0]   base_address,
  input  logic [PNL_BRAM_ADDR_SIZE_NB-1:0]   upper_limit,
  input  logic                               CP_req,
  input  logic [PNL_BRAM_DBITS_WIDTH_NB-1:0] CP_din,
  output logic                               PL_ack,
  output logic [PNL_BRAM_DBITS_WIDTH_NB-1:0] PL_dout,
  output logic [PNL_BRAM_ADDR_SIZE_NB-1:0]   BRAM_addr,
  output logic [PNL_BRAM_DBITS_WIDTH_NB-1:0] BRAM_din,
  output logic                               BRAM_we,
  input  logic [PNL_BRAM_DBITS_WIDTH_NB-1:0] BRAM_dout
);

  localparam int unsigned AW = PNL_BRAM_ADDR_SIZE_NB;
  localparam int unsigned DW = PNL_BRAM_DBITS_WIDTH_NB;

  typedef enum logic [2:0] {
    StIdle,
    StWaitReq,
    StWrite,
    StRead,
    StAck
  } state_e;

  state_e          state_q, state_d;
  logic            unload_q, unload_d;
  logic [AW-1:0]   upper_q, upper_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic [DW-1:0]   dout_q, dout_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      unload_q <= 1'b0;
      upper_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      unload_q <= unload_d;
      upper_q  <= upper_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    unload_d = unload_q;
    upper_d  = upper_q;
    addr_d   = addr_q;
    din_d    = din_q;
    dout_d   = dout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          unload_d = load_unload;
          upper_d  = upper_limit;
          addr_d   = base_address;
          state_d  = StWaitReq;
        end
      end
      StWaitReq: begin
        if (CP_req) begin
          if (unload_q) begin
            state_d = StRead;
          end else begin
            din_d   = CP_din;
            state_d = StWrite;
          end
        end
      end
      StWrite: state_d = StAck;
      StRead: begin
        // Address has been stable since WAIT_REQ, so the 1-cycle read data is valid now.
        dout_d  = BRAM_dout;
        state_d = StAck;
      end
      StAck: begin
        if (!CP_req) begin
          if (addr_q == upper_q) begin
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StWaitReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All outputs are state decodes or registers; no input-to-output paths.
  assign ready     = (state_q == StIdle);
  assign PL_ack    = (state_q == StAck);
  assign BRAM_we   = (state_q == StWrite);
  assign BRAM_addr = addr_q;
  assign BRAM_din  = din_q;
  assign PL_dout   = dout_q;

endmodule

// File: tb/tb_load_unload_mem.sv
// Randomised bench for load_unload_mem: drives the C side, models the BRAM, and
// checks writes/reads against an address-list reference of each transfer.
module tb_load_unload_mem;

  localparam int AW = 14;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          ready;
  logic          load_unload = 1'b0;
  logic [AW-1:0] base_address = '0;
  logic [AW-1:0] upper_limit = '0;
  logic          CP_req = 1'b0;
  logic [DW-1:0] CP_din = '0;
  logic          PL_ack;
  logic [DW-1:0] PL_dout;
  logic [AW-1:0] BRAM_addr;
  logic [DW-1:0] BRAM_din;
  logic          BRAM_we;
  logic [DW-1:0] BRAM_dout;

  load_unload_mem #(
    .PNL_BRAM_ADDR_SIZE_NB  (AW),
    .PNL_BRAM_DBITS_WIDTH_NB(DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ready       (ready),
    .load_unload (load_unload),
    .base_address(base_address),
    .upper_limit (upper_limit),
    .CP_req      (CP_req),
    .CP_din      (CP_din),
    .PL_ack      (PL_ack),
    .PL_dout     (PL_dout),
    .BRAM_addr   (BRAM_addr),
    .BRAM_din    (BRAM_din),
    .BRAM_we     (BRAM_we),
    .BRAM_dout   (BRAM_dout)
  );

  always #5 clk = ~clk;

  // BRAM model with a side port so the bench can preload words while the DUT idles.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    BRAM_dout <= mem[BRAM_addr];
    if (BRAM_we) mem[BRAM_addr] <= BRAM_din;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  // Every write-enable cycle is logged; a stretched pulse shows up as an extra entry.
  logic [31:0] wr_log [$];
  always @(negedge clk) begin
    if (BRAM_we) wr_log.push_back({2'b00, BRAM_addr, BRAM_din});
  end

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic poke_range(input logic [AW-1:0] b, input logic [AW-1:0] u);
    logic [AW-1:0] a;
    a = b;
    forever begin
      poke(a, DW'($urandom));
      if (a == u) break;
      a = a + 1'b1;
    end
  endtask

  // One transfer from the controller's view. abort_word >= 0 resets during that word's ACK.
  task automatic do_transfer(input bit unl, input logic [AW-1:0] b, input logic [AW-1:0] u,
                             input bit seq_data, input int hold, input bit poke_start,
                             input int abort_word);
    logic [AW-1:0] diff, a, na;
    logic [DW-1:0] d;
    logic [31:0]   exp_q [$];
    int n, k, log_base;
    n = int'(diff) + 1;
    diff = u - b;
    n = int'(diff) + 1;
    log_base = wr_log.size();
    @(posedge clk); #1;
    start = 1'b1; load_unload = unl; base_address = b; upper_limit = u;
    @(posedge clk); #1;
    start = 1'b0;
    base_address = AW'($urandom); upper_limit = AW'($urandom); load_unload = ~unl;
    check_eq("ready_low_after_start", 32'(ready), 32'd0);
    check_eq("addr_base", 32'(BRAM_addr), 32'(b));
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d = seq_data ? (16'hA000 + 16'(i)) : DW'($urandom);
      CP_din = d; CP_req = 1'b1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!PL_ack && k < 20);
      check_eq("ack_latency", 32'(k), 32'd2);
      if (unl) begin
        check_eq("pl_dout", 32'(PL_dout), 32'(ref_mem[a]));
      end else begin
        ref_mem[a] = d;
        exp_q.push_back({2'b00, a, d});
      end
      CP_din = DW'($urandom);
      if (i == abort_word) begin
        reset = 1'b0; #1;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_ack", 32'(PL_ack), 32'd0);
        check_eq("rst_we", 32'(BRAM_we), 32'd0);
        check_eq("rst_addr", 32'(BRAM_addr), 32'd0);
        CP_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        break;
      end
      for (int h = 0; h < hold; h++) begin
        start = (poke_start && h == 3);
        if (start) begin
          base_address = b + 14'd100; upper_limit = b + 14'd200; load_unload = ~unl;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("ack_held", 32'(PL_ack), 32'd1);
      end
      CP_req = 1'b0;
      @(posedge clk); #1;
      check_eq("ack_fall", 32'(PL_ack), 32'd0);
      if (i == n - 1) begin
        check_eq("ready_end", 32'(ready), 32'd1);
      end else begin
        na = a + 1'b1;
        check_eq("ready_busy", 32'(ready), 32'd0);
        check_eq("addr_inc", 32'(BRAM_addr), 32'(na));
      end
    end
    @(posedge clk); #1;
    check_eq("we_count", 32'(wr_log.size() - log_base), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && log_base + j < wr_log.size(); j++)
      check_eq("we_word", wr_log[log_base + j], exp_q[j]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] rb, ru;
    logic [DW-1:0] dout_keep;
    bit            ru_mode;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ready", 32'(ready), 32'd1);
    check_eq("reset_ack", 32'(PL_ack), 32'd0);
    check_eq("reset_we", 32'(BRAM_we), 32'd0);
    check_eq("reset_addr", 32'(BRAM_addr), 32'd0);
    check_eq("reset_din", 32'(BRAM_din), 32'd0);
    check_eq("reset_dout", 32'(PL_dout), 32'd0);
    reset = 1'b1;

    do_transfer(1'b0, 14'h010, 14'h013, 1'b1, 0, 1'b0, -1);

    poke(14'h100, 16'h5A5A);
    poke(14'h101, 16'h1234);
    poke(14'h102, 16'hFFFF);
    do_transfer(1'b1, 14'h100, 14'h102, 1'b0, 0, 1'b0, -1);
    dout_keep = PL_dout;
    do_transfer(1'b0, 14'h180, 14'h181, 1'b0, 0, 1'b0, -1);
    check_eq("dout_hold", 32'(PL_dout), 32'(dout_keep));

    do_transfer(1'b0, 14'h3FFE, 14'h0001, 1'b0, 0, 1'b0, -1);
    do_transfer(1'b0, 14'h0050, 14'h0050, 1'b0, 0, 1'b0, -1);
    do_transfer(1'b0, 14'h0200, 14'h0202, 1'b0, 10, 1'b1, -1);

    do_transfer(1'b0, 14'h0300, 14'h0304, 1'b0, 0, 1'b0, 1);
    do_transfer(1'b0, 14'h0300, 14'h0304, 1'b0, 0, 1'b0, -1);
    do_transfer(1'b1, 14'h0300, 14'h0304, 1'b0, 0, 1'b0, -1);

    for (int t = 0; t < 10; t++) begin
      rb = AW'($urandom);
      ru = rb + AW'($urandom_range(0, 5));
      ru_mode = 1'($urandom);
      if (ru_mode) poke_range(rb, ru);
      do_transfer(ru_mode, rb, ru, 1'b0, $urandom_range(0, 2), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
